// File: rtl/aes_iter_core.sv
// aes_iter_core: iterative AES-128/192/256 encrypt/decrypt engine, one round per clock,
// with an on-chip key schedule expanded one word per cycle into a round-key store.
module aes_iter_core #(
    parameter int unsigned KEY_BITS = 256
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         key_valid_i,
    input  logic [255:0] key_i,
    output logic         key_ready_o,
    input  logic         in_valid_i,
    input  logic         mode_i,
    input  logic [127:0] data_i,
    output logic         in_ready_o,
    output logic [127:0] data_o,
    output logic         out_valid_o,
    input  logic         out_ready_i,
    output logic         busy_o,
    output logic         key_loaded_o
);
    localparam int unsigned NK = KEY_BITS / 32;
    localparam int unsigned NR = NK + 6;
    localparam int unsigned NW = 4 * (NR + 1);
    localparam int unsigned WW = $clog2(NW);
    localparam int unsigned RW = 4;

    if (KEY_BITS != 128 && KEY_BITS != 192 && KEY_BITS != 256) begin : g_bad_key_bits
        $error("aes_iter_core: KEY_BITS must be 128, 192 or 256");
    end

    typedef enum logic [2:0] {NOKEY, EXPAND, IDLE, RUN, DONE} state_t;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = 8'h00;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = xtime(p);
        end
        return acc;
    endfunction

    // Forward and inverse S-box share one GF(2^8) inversion (x^254); only the affine step differs.
    function automatic logic [7:0] sbox(input logic [7:0] x, input logic inv);
        logic [7:0] a;
        logic [7:0] p;
        logic [7:0] r;
        a = inv ? ({x[6:0], x[7]} ^ {x[4:0], x[7:5]} ^ {x[1:0], x[7:2]} ^ 8'h05) : x;
        p = a;
        r = 8'h01;
        for (int i = 0; i < 7; i++) begin
            p = gf_mul(p, p);
            r = gf_mul(r, p);
        end
        return inv ? r : (r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                          ^ {r[3:0], r[7:4]} ^ 8'h63);
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        for (int k = 0; k < 16; k++) o[8*k +: 8] = sbox(s[8*k +: 8], inv);
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        int unsigned  src;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                src = inv ? 32'((c + 4 - r) % 4) : 32'((c + r) % 4);
                o[127 - 8*(4*c + r) -: 8] = s[127 - 8*(4*src + r) -: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [31:0] mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3, t;
        {a0, a1, a2, a3} = col;
        t = a0 ^ a1 ^ a2 ^ a3;
        return {a0 ^ t ^ xtime(a0 ^ a1), a1 ^ t ^ xtime(a1 ^ a2),
                a2 ^ t ^ xtime(a2 ^ a3), a3 ^ t ^ xtime(a3 ^ a0)};
    endfunction

    // InvMixColumns as a cheap pre-conditioning step followed by the forward MixColumns.
    function automatic logic [127:0] mix_cols(input logic [127:0] s, input logic inv);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3, u, v;
        for (int c = 0; c < 4; c++) begin
            {a0, a1, a2, a3} = s[127 - 32*c -: 32];
            u = inv ? xtime(xtime(a0 ^ a2)) : 8'h00;
            v = inv ? xtime(xtime(a1 ^ a3)) : 8'h00;
            o[127 - 32*c -: 32] = mix_col({a0 ^ u, a1 ^ v, a2 ^ u, a3 ^ v});
        end
        return o;
    endfunction

    state_t         state, state_nx;
    logic [127:0]   st;
    logic [RW-1:0]  round;
    logic           mode;
    logic [WW-1:0]  widx;
    logic [2:0]     kmod;
    logic [7:0]     rcon;
    logic           key_loaded;
    logic [31:0]    rk_mem [NW];

    logic           accept_key, accept_data, last;
    logic [RW-1:0]  rk_idx;
    logic [WW-1:0]  base;
    logic [127:0]   rk_sel, sb, mc, kr, round_out;
    logic [31:0]    prev, rot, subw, temp, new_word;
    logic           unused_key;

    assign unused_key   = ^key_i;
    assign accept_key   = key_valid_i && key_ready_o;
    assign accept_data  = in_valid_i && in_ready_o;
    assign data_o       = st;
    assign out_valid_o  = (state == DONE);
    assign busy_o       = (state == EXPAND) || (state == RUN);
    assign key_loaded_o = key_loaded;

    always_ff @(posedge clk) begin
        if (rst) state <= NOKEY;
        else     state <= state_nx;
    end

    // A block offered in IDLE wins over a simultaneous key; the key then waits.
    always_comb begin
        state_nx    = state;
        key_ready_o = 1'b0;
        in_ready_o  = 1'b0;
        case (state)
            NOKEY: begin
                key_ready_o = 1'b1;
                if (key_valid_i) state_nx = EXPAND;
            end
            EXPAND: if (widx == WW'(NW - 1)) state_nx = IDLE;
            IDLE: begin
                in_ready_o  = 1'b1;
                key_ready_o = !in_valid_i;
                if (in_valid_i)       state_nx = RUN;
                else if (key_valid_i) state_nx = EXPAND;
            end
            RUN: if (round == RW'(NR)) state_nx = DONE;
            DONE: begin
                in_ready_o = out_ready_i;
                if (out_ready_i) state_nx = in_valid_i ? RUN : IDLE;
            end
            default: state_nx = NOKEY;
        endcase
    end

    // Round datapath: encrypt uses rk[r]; decrypt is the equivalent inverse cipher on rk[NR-r].
    always_comb begin
        rk_idx = mode ? RW'(NR) - round : round;
        if (accept_data) rk_idx = mode_i ? RW'(NR) : '0;
        base      = WW'(4 * rk_idx);
        rk_sel    = {rk_mem[base], rk_mem[base + WW'(1)], rk_mem[base + WW'(2)], rk_mem[base + WW'(3)]};
        last      = (round == RW'(NR));
        sb        = sub_bytes(shift_rows(st, mode), mode);
        mc        = mix_cols(sb, mode);
        kr        = (mode && !last) ? mix_cols(rk_sel, 1'b1) : rk_sel;
        round_out = (last ? sb : mc) ^ kr;
    end

    always_comb begin
        prev = rk_mem[widx - WW'(1)];
        rot  = (kmod == 3'd0) ? {prev[23:0], prev[31:24]} : prev;
        subw = {sbox(rot[31:24], 1'b0), sbox(rot[23:16], 1'b0),
                sbox(rot[15:8], 1'b0), sbox(rot[7:0], 1'b0)};
        if (kmod == 3'd0)                 temp = subw ^ {rcon, 24'h000000};
        else if (NK == 8 && kmod == 3'd4) temp = subw;
        else                              temp = prev;
        new_word = rk_mem[widx - WW'(NK)] ^ temp;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st         <= '0;
            round      <= '0;
            mode       <= 1'b0;
            widx       <= WW'(NK);
            kmod       <= '0;
            rcon       <= 8'h01;
            key_loaded <= 1'b0;
        end else begin
            if (accept_key) begin
                widx       <= WW'(NK);
                kmod       <= '0;
                rcon       <= 8'h01;
                key_loaded <= 1'b0;
            end else if (state == EXPAND) begin
                widx <= widx + WW'(1);
                kmod <= (kmod == 3'(NK - 1)) ? 3'd0 : kmod + 3'd1;
                if (kmod == 3'd0) rcon <= xtime(rcon);
                if (widx == WW'(NW - 1)) key_loaded <= 1'b1;
            end
            if (accept_data) begin
                mode  <= mode_i;
                st    <= data_i ^ rk_sel;
                round <= RW'(1);
            end else if (state == RUN) begin
                st <= round_out;
                if (!last) round <= round + RW'(1);
            end
        end
    end

    // Round-key store carries no reset; key_loaded gates its use.
    always_ff @(posedge clk) begin
        if (accept_key) begin
            for (int unsigned j = 0; j < NK; j++) rk_mem[WW'(j)] <= key_i[255 - 32*j -: 32];
        end else if (state == EXPAND) begin
            rk_mem[widx] <= new_word;
        end
    end
endmodule

// File: tb/tb_aes_iter_core.sv
// Directed bench for aes_iter_core: three instances (AES-128/192/256) checked against
// FIPS-197 / SP800-38A vectors, plus backpressure, streaming, key-during-RUN and mid-RUN reset.
module tb_aes_iter_core;
    logic         clk = 1'b0;
    logic         rst        [3];
    logic         key_valid  [3];
    logic [255:0] key        [3];
    logic         key_ready  [3];
    logic         in_valid   [3];
    logic         mode       [3];
    logic [127:0] din        [3];
    logic         in_ready   [3];
    logic [127:0] dout       [3];
    logic         out_valid  [3];
    logic         out_ready  [3];
    logic         busy       [3];
    logic         key_loaded [3];

    for (genvar g = 0; g < 3; g++) begin : g_dut
        aes_iter_core #(.KEY_BITS(128 + 64*g)) u_dut (
            .clk          (clk),
            .rst          (rst[g]),
            .key_valid_i  (key_valid[g]),
            .key_i        (key[g]),
            .key_ready_o  (key_ready[g]),
            .in_valid_i   (in_valid[g]),
            .mode_i       (mode[g]),
            .data_i       (din[g]),
            .in_ready_o   (in_ready[g]),
            .data_o       (dout[g]),
            .out_valid_o  (out_valid[g]),
            .out_ready_i  (out_ready[g]),
            .busy_o       (busy[g]),
            .key_loaded_o (key_loaded[g])
        );
    end

    always #5 clk = ~clk;

    localparam logic [127:0] PT   = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] PT2  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT2  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [255:0] KEYB = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};

    logic [255:0] keys [3];
    logic [127:0] cts  [3];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_reset(input int k);
        check($sformatf("k%0d_rst_flags", k),
              128'({key_ready[k], in_ready[k], out_valid[k], busy[k], key_loaded[k]}), 128'b10000);
        check($sformatf("k%0d_rst_data", k), dout[k], 128'h0);
    endtask

    // Offers a key, returns stall (negedges until ready) and cycles from acceptance to key_loaded.
    task automatic send_key(input int k, input logic [255:0] kv, output int stall, output int lat);
        key_valid[k] = 1'b1;
        key[k]       = kv;
        stall = 0;
        @(negedge clk);
        while (!key_ready[k] && stall < 200) begin
            @(negedge clk);
            stall++;
        end
        check($sformatf("k%0d_key_ready", k), 128'(key_ready[k]), 128'd1);
        @(posedge clk); #1;
        key_valid[k] = 1'b0;
        lat = 0;
        @(negedge clk);
        while (!key_loaded[k] && lat < 100) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic accept_block(input int k, input logic m, input logic [127:0] d);
        int n;
        @(posedge clk); #1;
        in_valid[k] = 1'b1;
        mode[k]     = m;
        din[k]      = d;
        n = 0;
        @(negedge clk);
        while (!in_ready[k] && n < 200) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("k%0d_in_ready", k), 128'(in_ready[k]), 128'd1);
        @(posedge clk); #1;
        in_valid[k] = 1'b0;
    endtask

    task automatic wait_result(input int k, output int lat, output logic [127:0] res);
        lat = 0;
        @(negedge clk);
        while (!out_valid[k] && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        res = dout[k];
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int           stall, lat, klat, bad, idx, nout;
        logic [127:0] res;
        logic [127:0] sd   [4];
        logic         sm   [4];
        logic [127:0] sexp [5];
        logic [127:0] got  [5];
        int           tt   [5];

        keys[0] = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
        keys[1] = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
        keys[2] = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        cts[0]  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        cts[1]  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
        cts[2]  = 128'h8ea2b7ca516745bfeafc49904b496089;
        for (int k = 0; k < 3; k++) begin
            rst[k] = 1'b1; key_valid[k] = 1'b0; key[k] = '0; in_valid[k] = 1'b0;
            mode[k] = 1'b0; din[k] = '0; out_ready[k] = 1'b1;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) rst[k] = 1'b0;
        @(negedge clk);
        for (int k = 0; k < 3; k++) check_reset(k);

        // Data offered before any key must be ignored.
        @(posedge clk); #1;
        in_valid[0] = 1'b1; din[0] = PT;
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (in_ready[0] || busy[0] || out_valid[0]) bad++;
        end
        check("k0_nokey_ignored", 128'(bad), 128'd0);
        @(posedge clk); #1;
        in_valid[0] = 1'b0;

        for (int k = 0; k < 3; k++) begin
            send_key(k, keys[k], stall, klat);
            check($sformatf("k%0d_key_lat", k), 128'(klat), 128'(40 + 6*k));
            accept_block(k, 1'b0, PT);
            wait_result(k, lat, res);
            check($sformatf("k%0d_enc", k), res, cts[k]);
            check($sformatf("k%0d_enc_lat", k), 128'(lat), 128'(10 + 2*k));
            accept_block(k, 1'b1, cts[k]);
            wait_result(k, lat, res);
            check($sformatf("k%0d_dec", k), res, PT);
            check($sformatf("k%0d_dec_lat", k), 128'(lat), 128'(10 + 2*k));
        end

        // Backpressure: result held for 20 cycles with a block waiting.
        sd[0] = PT;  sm[0] = 1'b0;
        sd[1] = cts[0]; sm[1] = 1'b1;
        sd[2] = cts[0]; sm[2] = 1'b1;
        sd[3] = PT;  sm[3] = 1'b0;
        sexp[0] = cts[0]; sexp[1] = cts[0]; sexp[2] = PT; sexp[3] = PT; sexp[4] = cts[0];
        @(posedge clk); #1;
        out_ready[0] = 1'b0;
        accept_block(0, 1'b0, PT);
        wait_result(0, lat, res);
        check("k0_bp_result", res, cts[0]);
        @(posedge clk); #1;
        in_valid[0] = 1'b1; mode[0] = sm[0]; din[0] = sd[0];
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (!out_valid[0] || dout[0] !== cts[0] || in_ready[0]) bad++;
        end
        check("k0_bp_hold", 128'(bad), 128'd0);

        // Release and stream four blocks back-to-back.
        @(posedge clk); #1;
        out_ready[0] = 1'b1;
        idx = 0; nout = 0;
        for (int i = 0; i < 5; i++) begin got[i] = '0; tt[i] = 0; end
        for (int cyc = 0; cyc < 70; cyc++) begin
            logic ohs, ihs;
            @(negedge clk);
            ohs = out_valid[0] && out_ready[0];
            ihs = in_valid[0] && in_ready[0];
            if (ohs && nout < 5) begin
                got[nout] = dout[0];
                tt[nout]  = cyc;
                nout++;
            end
            @(posedge clk); #1;
            if (ihs) begin
                idx++;
                if (idx < 4) begin
                    mode[0] = sm[idx];
                    din[0]  = sd[idx];
                end else begin
                    in_valid[0] = 1'b0;
                end
            end
        end
        check("k0_stream_count", 128'(nout), 128'd5);
        for (int i = 0; i < 5; i++) check($sformatf("k0_stream_data%0d", i), got[i], sexp[i]);
        for (int i = 1; i < 5; i++) check($sformatf("k0_stream_gap%0d", i), 128'(tt[i] - tt[i-1]), 128'd11);

        // New key offered while a block is in flight.
        accept_block(0, 1'b0, PT);
        fork
            send_key(0, KEYB, stall, klat);
            wait_result(0, lat, res);
        join
        check("k0_inflight_oldkey", res, cts[0]);
        check("k0_inflight_lat", 128'(lat), 128'd10);
        check("k0_key_stall", 128'(stall), 128'd11);
        check("k0_newkey_lat", 128'(klat), 128'd40);
        accept_block(0, 1'b0, PT2);
        wait_result(0, lat, res);
        check("k0_newkey_enc", res, CT2);
        accept_block(0, 1'b1, CT2);
        wait_result(0, lat, res);
        check("k0_newkey_dec", res, PT2);

        // Reset in the middle of RUN.
        accept_block(1, 1'b0, PT);
        repeat (5) @(posedge clk);
        #1;
        rst[1] = 1'b1;
        @(posedge clk); #1;
        rst[1] = 1'b0;
        @(negedge clk);
        check_reset(1);
        in_valid[1] = 1'b1; din[1] = PT; mode[1] = 1'b0;
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid[1] || in_ready[1] || key_loaded[1] || busy[1]) bad++;
        end
        check("k1_rst_quiet", 128'(bad), 128'd0);
        @(posedge clk); #1;
        in_valid[1] = 1'b0;
        send_key(1, keys[1], stall, klat);
        check("k1_reload_key_lat", 128'(klat), 128'd46);
        accept_block(1, 1'b0, PT);
        wait_result(1, lat, res);
        check("k1_after_rst_enc", res, cts[1]);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
